// File: rtl/mem_dp_be_pipe.sv
// One-write/one-read scratch RAM with byte-lane writes, an RD_LAT-deep read
// pipeline, selectable read-during-write result and a post-reset clear sweep.
module mem_dp_be_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0
) (
  input  logic                      CLK,
  input  logic                      Rst_n,
  input  logic                      Wr_En,
  input  logic [ADDR_WIDTH-1:0]     Wr_Addr,
  input  logic [DATA_WIDTH-1:0]     Wr_Data,
  input  logic [DATA_WIDTH/8-1:0]   Wr_Be,
  input  logic                      Rd_En,
  input  logic [ADDR_WIDTH-1:0]     Rd_Addr,
  output logic [DATA_WIDTH-1:0]     Data_out,
  output logic                      Valid_out,
  output logic                      Addr_err,
  output logic                      Init_busy
);

  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   init_cnt_reg, init_cnt_next;
  logic                    init_busy, run;
  logic                    wr_in_range, rd_in_range;
  logic                    wr_accept, wr_oor, rd_accept, rd_hit;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    s1_valid_reg, s1_err_reg, s1_hit_reg;
  logic [DATA_WIDTH-1:0]   s1_wdata_reg;
  logic [NB-1:0]           s1_wbe_reg;
  logic [DATA_WIDTH-1:0]   s1_word;
  logic                    wr_err_reg;
  logic [DATA_WIDTH-1:0]   out_data;
  logic                    out_valid, out_err;

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_reg    <= ST_INIT;
      init_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      init_cnt_reg <= init_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    init_cnt_next = init_cnt_reg;
    init_busy     = 1'b0;
    run           = 1'b0;
    case (state_reg)
      ST_INIT: begin
        init_busy     = 1'b1;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == LAST_ADDR) begin
          state_next    = ST_RUN;
          init_cnt_next = '0;
        end
      end
      ST_RUN:  run = 1'b1;
      default: state_next = ST_INIT;
    endcase
  end

  // Addresses are widened by one bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  assign wr_in_range = {1'b0, Wr_Addr} < DEPTH_W;
  assign rd_in_range = {1'b0, Rd_Addr} < DEPTH_W;
  assign wr_accept   = run & Wr_En & wr_in_range;
  assign wr_oor      = run & Wr_En & ~wr_in_range;
  assign rd_accept   = run & Rd_En;
  assign rd_hit      = wr_accept & rd_in_range & (Wr_Addr == Rd_Addr);

  // One RAM per byte lane; the registered read returns the pre-write word.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem_lane [DEPTH];
      logic [7:0] rd_q_reg;

      always_ff @(posedge CLK) begin
        if (init_busy)
          mem_lane[init_cnt_reg] <= '0;
        else if (wr_accept && Wr_Be[gi])
          mem_lane[Wr_Addr] <= Wr_Data[8*gi +: 8];
        if (rd_accept)
          rd_q_reg <= mem_lane[Rd_Addr];
      end

      assign rd_word[8*gi +: 8] = rd_q_reg;
    end
  endgenerate

  always_ff @(posedge CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_err_reg   <= 1'b0;
      s1_hit_reg   <= 1'b0;
      s1_wdata_reg <= '0;
      s1_wbe_reg   <= '0;
      wr_err_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= rd_accept;
      s1_err_reg   <= rd_accept & ~rd_in_range;
      s1_hit_reg   <= rd_accept & rd_hit;
      s1_wdata_reg <= Wr_Data;
      s1_wbe_reg   <= Wr_Be;
      wr_err_reg   <= wr_oor;
    end
  end

  // Forwarding of same-address write bytes happens after the RAM register.
  always_comb begin
    s1_word = '0;
    if (s1_valid_reg && !s1_err_reg) begin
      for (int i = 0; i < NB; i++) begin
        if (RDW_MODE == 1 && s1_hit_reg && s1_wbe_reg[i])
          s1_word[8*i +: 8] = s1_wdata_reg[8*i +: 8];
        else
          s1_word[8*i +: 8] = rd_word[8*i +: 8];
      end
    end
  end

  generate
    if (RD_LAT == 1) begin : g_lat1
      assign out_data  = s1_word;
      assign out_valid = s1_valid_reg;
      assign out_err   = s1_err_reg;
    end else begin : g_pipe
      logic [DATA_WIDTH-1:0] data_reg [RD_LAT-1];
      logic [RD_LAT-2:0]     valid_reg, err_reg;

      always_ff @(posedge CLK or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int i = 0; i < RD_LAT - 1; i++) data_reg[i] <= '0;
          valid_reg <= '0;
          err_reg   <= '0;
        end else begin
          data_reg[0]  <= s1_word;
          valid_reg[0] <= s1_valid_reg;
          err_reg[0]   <= s1_err_reg;
          for (int i = 1; i < RD_LAT - 1; i++) begin
            data_reg[i]  <= data_reg[i-1];
            valid_reg[i] <= valid_reg[i-1];
            err_reg[i]   <= err_reg[i-1];
          end
        end
      end

      assign out_data  = data_reg[RD_LAT-2];
      assign out_valid = valid_reg[RD_LAT-2];
      assign out_err   = err_reg[RD_LAT-2];
    end
  endgenerate

  assign Data_out  = out_data;
  assign Valid_out = out_valid;
  assign Addr_err  = wr_err_reg | (out_valid & out_err);
  assign Init_busy = init_busy;

endmodule

// File: tb/tb_mem_dp_be_pipe.sv
// Drives three differently-parameterised instances with shared stimulus and
// checks every output each cycle against a due-cycle scoreboard.
module tb_mem_dp_be_pipe;

  localparam int N = 3;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        re;
    logic [4:0]  raddr;
    logic [31:0] exp_m0;
    logic [31:0] exp_m1;
  } vec_t;

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        wr_en, rd_en;
  logic [4:0]  wr_addr, rd_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [31:0] dout [N];
  logic [N-1:0] vout, aerr, busy;

  int   cyc = 0;
  int   rel_cyc;
  int   werr_due [N];
  int   n_cmp, n_bad;
  bit   mon_en;
  exp_t sb [$];
  vec_t tbl [$];

  function automatic int dep_of(input int k);
    return (k == 1) ? 20 : 32;
  endfunction

  function automatic int lat_of(input int k);
    case (k)
      0:       return 3;
      1:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit mode_of(input int k);
    return (k != 0);
  endfunction

  mem_dp_be_pipe #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .RD_LAT(3), .RDW_MODE(0)) u_d0 (
    .CLK(clk), .Rst_n(rst_n), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Wr_Be(wr_be), .Rd_En(rd_en), .Rd_Addr(rd_addr), .Data_out(dout[0]),
    .Valid_out(vout[0]), .Addr_err(aerr[0]), .Init_busy(busy[0]));

  mem_dp_be_pipe #(.DATA_WIDTH(32), .DEPTH(20), .ADDR_WIDTH(5), .RD_LAT(1), .RDW_MODE(1)) u_d1 (
    .CLK(clk), .Rst_n(rst_n), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Wr_Be(wr_be), .Rd_En(rd_en), .Rd_Addr(rd_addr), .Data_out(dout[1]),
    .Valid_out(vout[1]), .Addr_err(aerr[1]), .Init_busy(busy[1]));

  mem_dp_be_pipe #(.DATA_WIDTH(32), .DEPTH(32), .ADDR_WIDTH(5), .RD_LAT(2), .RDW_MODE(1)) u_d2 (
    .CLK(clk), .Rst_n(rst_n), .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Wr_Be(wr_be), .Rd_En(rd_en), .Rd_Addr(rd_addr), .Data_out(dout[2]),
    .Valid_out(vout[2]), .Addr_err(aerr[2]), .Init_busy(busy[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc %0d: got %h expected %h", name, k, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                              input logic [3:0] be, input logic re, input logic [4:0] ra,
                              input logic [31:0] e0, input logic [31:0] e1);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.be = be;
    v.re = re; v.raddr = ra; v.exp_m0 = e0; v.exp_m1 = e1;
    return v;
  endfunction

  // Applies one cycle of stimulus and records what each accepting instance must produce.
  task automatic drive(input vec_t v);
    exp_t e;
    wr_en = v.we; wr_addr = v.waddr; wr_data = v.wdata; wr_be = v.be;
    rd_en = v.re; rd_addr = v.raddr;
    for (int k = 0; k < N; k++) begin
      if (rst_n && cyc >= rel_cyc + dep_of(k)) begin
        if (v.re) begin
          e.dut = k;
          e.due = cyc + lat_of(k);
          if (int'(v.raddr) >= dep_of(k)) begin
            e.data = '0;
            e.err  = 1'b1;
          end else begin
            e.data = mode_of(k) ? v.exp_m1 : v.exp_m0;
            e.err  = 1'b0;
          end
          sb.push_back(e);
          $display("rd dut%0d cyc %0d addr %0d -> expect %h err %0b at cyc %0d",
                   k, cyc, v.raddr, e.data, e.err, e.due);
        end
        if (v.we && int'(v.waddr) >= dep_of(k))
          werr_due[k] = cyc + 1;
      end
    end
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; wr_be = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit   found;
    if (mon_en) begin
      for (int k = 0; k < N; k++) begin
        found = 1'b0;
        e.data = '0;
        e.err  = 1'b0;
        foreach (sb[i]) begin
          if (sb[i].dut == k && sb[i].due == cyc) begin
            found = 1'b1;
            e = sb[i];
          end
        end
        check("valid_out", k, 32'(vout[k]), 32'(found));
        check("data_out", k, dout[k], found ? e.data : 32'h0);
        check("addr_err", k, 32'(aerr[k]), 32'((found && e.err) || werr_due[k] == cyc));
        check("init_busy", k, 32'(busy[k]), 32'(!rst_n || cyc < rel_cyc + dep_of(k)));
      end
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due <= cyc) sb.delete(i);
    end
  end

  initial begin
    clk = 1'b0; rst_n = 1'b1; mon_en = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = '0;
    rel_cyc = 1 << 30;
    n_cmp = 0; n_bad = 0;
    for (int k = 0; k < N; k++) werr_due[k] = -1;

    #2 rst_n = 1'b0;
    mon_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rel_cyc = cyc;

    // Traffic during the clear sweep must be ignored.
    idle(6);
    drive(mk(1, 3, 32'hFFFF_FFFF, 4'hF, 1, 3, 0, 0));
    drive(mk(1, 4, 32'h1234_5678, 4'hF, 1, 4, 0, 0));
    while (cyc < rel_cyc + 32) idle(1);

    // Every word reads back zero after the sweep, back-to-back.
    for (int a = 0; a < 32; a++) drive(mk(0, 0, 0, 0, 1, 5'(a), 0, 0));

    tbl.push_back(mk(1,  5, 32'hDEADBEEF, 4'hF,    0,  0, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  5, 32'hDEADBEEF, 32'hDEADBEEF));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  6, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  5, 32'hDEADBEEF, 32'hDEADBEEF));
    tbl.push_back(mk(1,  7, 32'h11223344, 4'hF,    0,  0, 32'h0,        32'h0));
    tbl.push_back(mk(1,  7, 32'hAABBCCDD, 4'b0101, 0,  0, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  7, 32'h11BB33DD, 32'h11BB33DD));
    tbl.push_back(mk(1,  9, 32'h12345678, 4'hF,    1,  9, 32'h0,        32'h12345678));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  9, 32'h12345678, 32'h12345678));
    tbl.push_back(mk(1, 25, 32'hA5A5A5A5, 4'hF,    0,  0, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  5, 32'hDEADBEEF, 32'hDEADBEEF));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1, 25, 32'hA5A5A5A5, 32'hA5A5A5A5));
    tbl.push_back(mk(1, 10, 32'hFFFFFFFF, 4'h0,    1, 10, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1, 10, 32'h0,        32'h0));
    tbl.push_back(mk(1, 11, 32'h01020304, 4'b1100, 1, 11, 32'h0,        32'h01020000));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1, 11, 32'h01020000, 32'h01020000));
    tbl.push_back(mk(1, 12, 32'h55667788, 4'hF,    1, 13, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1, 12, 32'h55667788, 32'h55667788));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  3, 32'h0,        32'h0));
    tbl.push_back(mk(0,  0, 32'h0,        4'h0,    1,  4, 32'h0,        32'h0));
    tbl.push_back(mk(1, 30, 32'h00000001, 4'hF,    1, 30, 32'h0,        32'h00000001));
    foreach (tbl[i]) drive(tbl[i]);
    idle(6);

    // Reset with reads still in flight: nothing may emerge, contents are cleared.
    drive(mk(0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'hDEADBEEF));
    drive(mk(0, 0, 0, 0, 1, 12, 32'h55667788, 32'h55667788));
    rst_n = 1'b0;
    sb.delete();
    for (int k = 0; k < N; k++) werr_due[k] = -1;
    $display("reset asserted cyc %0d with reads in flight", cyc);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    rel_cyc = cyc;
    while (cyc < rel_cyc + 32) idle(1);
    drive(mk(0, 0, 0, 0, 1,  5, 0, 0));
    drive(mk(0, 0, 0, 0, 1, 12, 0, 0));
    drive(mk(0, 0, 0, 0, 1,  7, 0, 0));
    idle(6);

    check("scoreboard_drained", 0, 32'(sb.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_dp_be_pipe.md
Name: mem_dp_be_pipe

Overview:
- Parametrised successor to the single-port 32-word memory.
- One write port and one read port are both active in the same cycle, with no mutual exclusion.
- Adds byte-lane write enables, a configurable read pipeline latency, a defined read-during-write rule and out-of-range address detection.
- Memory is cleared by a post-reset hardware init sequence, not a single-cycle array reset.
- Sits between the bus-side controller and datapath as the general scratch/storage RAM.

Parameters:
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 32, number of words; need not be a power of two.
- ADDR_WIDTH, 5, address width; ceil(log2(DEPTH)) <= ADDR_WIDTH.
- RD_LAT, 1, read latency in cycles from accepted read to Valid_out; legal 1..4.
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (byte-merged) data.

Ports:
- CLK  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- Wr_En  in  1  write request.
- Wr_Addr  in  ADDR_WIDTH  write address.
- Wr_Data  in  DATA_WIDTH  write data.
- Wr_Be  in  DATA_WIDTH/8  byte enables; bit i covers Wr_Data[8i+7:8i].
- Rd_En  in  1  read request.
- Rd_Addr  in  ADDR_WIDTH  read address.
- Data_out  out  DATA_WIDTH  read data; zero whenever Valid_out=0.
- Valid_out  out  1  Data_out valid, one-cycle pulse per accepted read.
- Addr_err  out  1  pulses with Valid_out for an out-of-range read; pulses one cycle after an out-of-range write.
- Init_busy  out  1  high while the clear sequence runs.

Behaviour:
- Reset (async assert, Rst_n=0):
  - Data_out=0, Valid_out=0, Addr_err=0, Init_busy=1.
  - Read pipeline valids cleared; FSM forced to INIT with clear counter=0.
- FSM states:
  - INIT: writes mem[cnt]=0 each cycle and increments cnt. When cnt==DEPTH-1, the next state is RUN, so the clear takes DEPTH cycles after Rst_n deasserts. Init_busy=1 throughout.
  - RUN: Init_busy=0. No exit except reset.
- In INIT, Wr_En and Rd_En are ignored entirely: no write, no Valid_out, no Addr_err.
- Write (RUN):
  - For each byte i with Wr_Be[i]=1, mem[Wr_Addr] byte i <= Wr_Data byte i at the clock edge.
  - Wr_Be=0 gives no change and no error.
- Read (RUN):
  - Address sampled when Rd_En=1.
  - Data_out/Valid_out appear exactly RD_LAT cycles later. RD_LAT=1 means registered output on the next edge.
  - Fully pipelined: one read per cycle sustained, back-to-back Valid_out pulses, order preserved.
- Read-during-write, same cycle, same in-range address:
  - RDW_MODE=0: read returns the pre-write word.
  - RDW_MODE=1: read returns the pre-write word with enabled bytes replaced by Wr_Data bytes.
  - Different addresses never interact.
- Out-of-range (addr >= DEPTH):
  - Write: memory unchanged (no aliasing); Addr_err pulses the next cycle.
  - Read: Valid_out still pulses at RD_LAT with Data_out=0 and Addr_err=1 in the same cycle.
  - If an out-of-range write and an out-of-range read error coincide in one cycle, Addr_err=1 (OR).
- Cycles with no accepted read output Data_out=0, Valid_out=0.
- Reset mid-operation: in-flight reads are discarded (no Valid_out emitted), memory is re-cleared via INIT, and stored content is not preserved.
- No simulation $error on simultaneous Wr_En/Rd_En; it is legal traffic.

Test Plan:
- Release reset with DEPTH=32: Init_busy=1 for exactly 32 cycles, then 0. A read of each address 0..31 returns 0 with Valid_out. Wr_En/Rd_En pulsed during INIT produce no Valid_out and no memory change.
- RD_LAT=3: write 0xDEADBEEF to addr 5, then read 5 → Valid_out exactly 3 cycles after Rd_En, Data_out=0xDEADBEEF. Reads of 5,6,5 back-to-back give three consecutive valid pulses in order.
- Byte enables: write 0x11223344 with Be=4'hF, then 0xAABBCCDD with Be=4'b0101 to addr 7 → read returns 0x11BB33DD.
- Read-during-write: addr 9 holds 0x0, then a simultaneous write 0x12345678 (Be=F) and read of 9 → RDW_MODE=0 returns 0x00000000, RDW_MODE=1 returns 0x12345678. Next read returns 0x12345678 in both modes.
- Out-of-range with DEPTH=20, ADDR_WIDTH=5: write addr 25 → Addr_err pulse next cycle, addr 5 unchanged. Read addr 25 → Valid_out=1, Data_out=0, Addr_err=1 in the same cycle.
- Assert Rst_n=0 with two reads in flight (RD_LAT=2) → outputs zero immediately, no Valid_out after release, INIT reruns, previously written data reads 0.
